// File: rtl/adder_traffic_master.sv
// Traffic master for the flow-control adder: issues LFSR operand pairs over a
// valid/ready interface, accepts sums with optional LFSR backpressure and
// checks each sum against an in-order queue of expected values.
//
// Ports
//   clk, rst              clock (rising edge), asynchronous active-high reset
//   start, num_txn        run request (IDLE/DONE only) and run length
//   a_valid, a_ready      operand handshake; a, b are the operands
//   sum_valid, sum_ready  result handshake; sum is the W+1 bit result
//   busy, done            RUN/DRAIN and DONE state flags
//   err_cnt, first_err    mismatch count (saturating) and index of first mismatch
module adder_traffic_master #(
    parameter int unsigned W     = 4,
    parameter int unsigned DEPTH = 4,
    parameter logic [7:0]  SEED  = 8'hA5,
    parameter bit          BP_EN = 1'b1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    input  logic [15:0]   num_txn,
    output logic          a_valid,
    input  logic          a_ready,
    output logic [W-1:0]  a,
    output logic [W-1:0]  b,
    input  logic          sum_valid,
    output logic          sum_ready,
    input  logic [W:0]    sum,
    output logic          busy,
    output logic          done,
    output logic [7:0]    err_cnt,
    output logic [15:0]   first_err
);

    localparam int unsigned SW = W + 1;
    localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CW = PW + 1;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RUN   = 2'd1,
        S_DRAIN = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t          state_q, state_d;
    logic [7:0]      lfsr_q, lfsr_d;
    logic [7:0]      bp_q, bp_d;
    logic [15:0]     num_q, num_d;
    logic [15:0]     issued_q, issued_d;
    logic [15:0]     checked_q, checked_d;
    logic [PW-1:0]   wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]   rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]   count_q, count_d;
    logic [SW-1:0]   mem_q [DEPTH];
    logic [SW-1:0]   mem_d [DEPTH];
    logic [7:0]      err_cnt_q, err_cnt_d;
    logic [15:0]     first_err_q, first_err_d;
    logic            a_valid_q, a_valid_d;
    logic            sum_ready_q, sum_ready_d;
    logic            busy_q, busy_d;
    logic            done_q, done_d;

    logic            push;
    logic            pop;

    // Fibonacci LFSR, taps 8,6,5,4
    function automatic logic [7:0] lfsr_step(input logic [7:0] v);
        return {v[6:0], v[7] ^ v[5] ^ v[4] ^ v[3]};
    endfunction

    assign push = a_valid_q & a_ready;
    assign pop  = sum_ready_q & sum_valid;

    // Next-state, queue and scoreboard logic
    always_comb begin
        state_d     = state_q;
        lfsr_d      = lfsr_q;
        bp_d        = lfsr_step(bp_q);
        num_d       = num_q;
        issued_d    = issued_q;
        checked_d   = checked_q;
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        count_d     = count_q;
        mem_d       = mem_q;
        err_cnt_d   = err_cnt_q;
        first_err_d = first_err_q;

        if (push) begin
            mem_d[wr_ptr_q] = SW'(lfsr_q[W-1:0]) + SW'(lfsr_q[2*W-1:W]);
            wr_ptr_d        = wr_ptr_q + PW'(1);
            issued_d        = issued_q + 16'd1;
            lfsr_d          = lfsr_step(lfsr_q);
        end

        if (pop) begin
            rd_ptr_d  = rd_ptr_q + PW'(1);
            checked_d = checked_q + 16'd1;
            if (mem_q[rd_ptr_q] != sum) begin
                if (err_cnt_q != 8'hFF) begin
                    err_cnt_d = err_cnt_q + 8'd1;
                end
                if (first_err_q == 16'hFFFF) begin
                    first_err_d = checked_q;
                end
            end
        end

        unique case ({push, pop})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase

        unique case (state_q)
            S_IDLE, S_DONE: begin
                if (start) begin
                    num_d       = num_txn;
                    issued_d    = 16'd0;
                    checked_d   = 16'd0;
                    err_cnt_d   = 8'd0;
                    first_err_d = 16'hFFFF;
                    state_d     = (num_txn == 16'd0) ? S_DONE : S_RUN;
                end
            end
            S_RUN: begin
                if (issued_d == num_q) begin
                    state_d = (checked_d == num_q) ? S_DONE : S_DRAIN;
                end
            end
            S_DRAIN: begin
                if (checked_d == num_q) begin
                    state_d = S_DONE;
                end
            end
            default: state_d = S_IDLE;
        endcase

        // Outputs are registered from next-state values so they line up with state_q
        a_valid_d   = (state_d == S_RUN) && (issued_d < num_d) && (count_d < CW'(DEPTH));
        sum_ready_d = ((state_d == S_RUN) || (state_d == S_DRAIN)) && (count_d != CW'(0)) &&
                      (BP_EN ? bp_d[7] : 1'b1);
        busy_d      = (state_d == S_RUN) || (state_d == S_DRAIN);
        done_d      = (state_d == S_DONE);
    end

    // State and output registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= S_IDLE;
            lfsr_q      <= SEED;
            bp_q        <= ~SEED;
            num_q       <= 16'd0;
            issued_q    <= 16'd0;
            checked_q   <= 16'd0;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            for (int unsigned i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            err_cnt_q   <= 8'd0;
            first_err_q <= 16'hFFFF;
            a_valid_q   <= 1'b0;
            sum_ready_q <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            lfsr_q      <= lfsr_d;
            bp_q        <= bp_d;
            num_q       <= num_d;
            issued_q    <= issued_d;
            checked_q   <= checked_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            mem_q       <= mem_d;
            err_cnt_q   <= err_cnt_d;
            first_err_q <= first_err_d;
            a_valid_q   <= a_valid_d;
            sum_ready_q <= sum_ready_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
        end
    end

    assign a_valid   = a_valid_q;
    assign a         = lfsr_q[W-1:0];
    assign b         = lfsr_q[2*W-1:W];
    assign sum_ready = sum_ready_q;
    assign busy      = busy_q;
    assign done      = done_q;
    assign err_cnt   = err_cnt_q;
    assign first_err = first_err_q;

endmodule

// File: tb/tb_adder_traffic_master.sv
// Bench for adder_traffic_master: a seed-A5 instance driven through normal,
// corrupted, stalled, sum-starved and reset-interrupted runs, plus a seed-FF
// instance whose first operands F+F exercise the full-carry expected sum.
module tb_adder_traffic_master;

    logic        clk = 1'b0;
    logic        rst;

    // seed A5 instance
    logic        start;
    logic [15:0] num_txn;
    logic        a_valid, a_ready, sum_valid, sum_ready, busy, done;
    logic [3:0]  a, b;
    logic [4:0]  sum;
    logic [7:0]  err_cnt;
    logic [15:0] first_err;

    // seed FF instance
    logic        start_f;
    logic [15:0] num_txn_f;
    logic        a_valid_f, a_ready_f, sum_valid_f, sum_ready_f, busy_f, done_f;
    logic [3:0]  a_f, b_f;
    logic [4:0]  sum_f;
    logic [7:0]  err_cnt_f;
    logic [15:0] first_err_f;

    int n_checks = 0;
    int n_pass   = 0;

    always #5 clk = ~clk;

    adder_traffic_master #(.W(4), .DEPTH(4), .SEED(8'hA5), .BP_EN(1'b0)) u_dut (
        .clk(clk), .rst(rst), .start(start), .num_txn(num_txn),
        .a_valid(a_valid), .a_ready(a_ready), .a(a), .b(b),
        .sum_valid(sum_valid), .sum_ready(sum_ready), .sum(sum),
        .busy(busy), .done(done), .err_cnt(err_cnt), .first_err(first_err)
    );

    adder_traffic_master #(.W(4), .DEPTH(4), .SEED(8'hFF), .BP_EN(1'b0)) u_dut_f (
        .clk(clk), .rst(rst), .start(start_f), .num_txn(num_txn_f),
        .a_valid(a_valid_f), .a_ready(a_ready_f), .a(a_f), .b(b_f),
        .sum_valid(sum_valid_f), .sum_ready(sum_ready_f), .sum(sum_f),
        .busy(busy_f), .done(done_f), .err_cnt(err_cnt_f), .first_err(first_err_f)
    );

    // Hand-computed LFSR sequences as {b,a} bytes
    logic [7:0] seq_a5 [10] = '{8'hA5, 8'h4A, 8'h95, 8'h2A, 8'h54,
                                8'hA9, 8'h53, 8'hA7, 8'h4E, 8'h9D};
    logic [7:0] seq_ff [6]  = '{8'hFF, 8'hFE, 8'hFC, 8'hF8, 8'hF0, 8'hE1};

    logic [7:0] exp_q [$];
    logic [7:0] exp_f [$];
    bit         chk_ops;
    int         op_xfers = 0;

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    task automatic fail_now(input string name);
        n_checks++;
        $display("FAIL %s: event missing", name);
    endtask

    // Responder for the A5 instance: one result register, optional stall,
    // drop mode (accepts operands, never returns) and single-sum corruption.
    logic res_v;
    logic [4:0] res_s;
    int   rsp_idx;
    int   corrupt_at;
    bit   stall, drop;

    assign a_ready   = !stall && (drop || !res_v || sum_ready);
    assign sum_valid = res_v;
    assign sum       = res_s;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            res_v   <= 1'b0;
            res_s   <= 5'd0;
            rsp_idx <= 0;
        end else begin
            if (start) rsp_idx <= 0;
            if (sum_valid && sum_ready) res_v <= 1'b0;
            if (a_valid && a_ready) begin
                rsp_idx <= rsp_idx + 1;
                if (!drop) begin
                    res_v <= 1'b1;
                    res_s <= ({1'b0, a} + {1'b0, b}) ^ ((rsp_idx == corrupt_at) ? 5'd1 : 5'd0);
                end
            end
        end
    end

    // Ideal responder for the FF instance
    logic res_vf;
    logic [4:0] res_sf;
    assign a_ready_f   = !res_vf || sum_ready_f;
    assign sum_valid_f = res_vf;
    assign sum_f       = res_sf;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            res_vf <= 1'b0;
            res_sf <= 5'd0;
        end else begin
            if (sum_valid_f && sum_ready_f) res_vf <= 1'b0;
            if (a_valid_f && a_ready_f) begin
                res_vf <= 1'b1;
                res_sf <= {1'b0, a_f} + {1'b0, b_f};
            end
        end
    end

    // Operand monitors: handshake seen at negedge completes on the next posedge
    always @(negedge clk) begin
        if (!rst && a_valid && a_ready) begin
            op_xfers++;
            if (chk_ops) begin
                if (exp_q.size() == 0) fail_now("op_extra");
                else check("op_ab", {8'h00, b, a}, {8'h00, exp_q.pop_front()});
            end
        end
        if (!rst && a_valid_f && a_ready_f) begin
            if (exp_f.size() == 0) fail_now("op_f_extra");
            else check("op_f_ab", {8'h00, b_f, a_f}, {8'h00, exp_f.pop_front()});
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_start(input logic [15:0] n);
        num_txn = n;
        start   = 1'b1;
        tick();
        start   = 1'b0;
    endtask

    task automatic wait_done(input bit which, input int max);
        int k;
        for (k = 0; k < max; k++) begin
            if (which ? done_f : done) break;
            tick();
        end
        if (k == max) fail_now(which ? "done_f_timeout" : "done_timeout");
    endtask

    task automatic load_a5();
        for (int i = 0; i < 10; i++) exp_q.push_back(seq_a5[i]);
    endtask

    initial begin
        int x0;
        int k;
        rst = 1'b1; start = 1'b0; num_txn = 16'd0;
        start_f = 1'b0; num_txn_f = 16'd6;
        stall = 1'b0; drop = 1'b0; corrupt_at = -1; chk_ops = 1'b0;
        repeat (3) tick();

        // Reset values
        check("rst_a_valid", 16'(a_valid), 16'h0);
        check("rst_sum_ready", 16'(sum_ready), 16'h0);
        check("rst_busy", 16'(busy), 16'h0);
        check("rst_done", 16'(done), 16'h0);
        check("rst_err_cnt", 16'(err_cnt), 16'h0);
        check("rst_first_err", first_err, 16'hFFFF);
        rst = 1'b0;
        tick();

        // Zero-length run finishes one cycle after start
        pulse_start(16'd0);
        check("t5_done", 16'(done), 16'h1);
        check("t5_busy", 16'(busy), 16'h0);
        check("t5_a_valid", 16'(a_valid), 16'h0);

        // Ideal run of 10, alongside the seed-FF run of 6
        load_a5();
        chk_ops = 1'b1;
        for (int i = 0; i < 6; i++) exp_f.push_back(seq_ff[i]);
        x0 = op_xfers;
        start_f = 1'b1;
        pulse_start(16'd10);
        start_f = 1'b0;
        check("t1_a_valid_latency", 16'(a_valid), 16'h1);
        check("t1_first_a", 16'(a), 16'h5);
        wait_done(1'b0, 200);
        check("t1_xfers", 16'(op_xfers - x0), 16'd10);
        check("t1_err_cnt", 16'(err_cnt), 16'h0);
        check("t1_first_err", first_err, 16'hFFFF);
        check("t1_busy", 16'(busy), 16'h0);
        check("t1_queue_left", 16'(exp_q.size()), 16'h0);
        wait_done(1'b1, 200);
        check("ff_err_cnt", 16'(err_cnt_f), 16'h0);
        check("ff_first_err", first_err_f, 16'hFFFF);
        check("ff_queue_left", 16'(exp_f.size()), 16'h0);

        // Third sum corrupted
        chk_ops = 1'b0;
        corrupt_at = 2;
        pulse_start(16'd5);
        wait_done(1'b0, 200);
        check("t2_err_cnt", 16'(err_cnt), 16'h1);
        check("t2_first_err", first_err, 16'h2);
        corrupt_at = -1;

        // Responder never returns sums: issue stops at queue depth
        drop = 1'b1;
        pulse_start(16'd8);
        x0 = op_xfers;
        repeat (30) tick();
        check("t4_xfers", 16'(op_xfers - x0), 16'd4);
        check("t4_a_valid", 16'(a_valid), 16'h0);
        check("t4_busy", 16'(busy), 16'h1);
        check("t4_done", 16'(done), 16'h0);
        check("t4_sum_ready", 16'(sum_ready), 16'h1);

        // Reset mid-run returns to reset values at once
        rst = 1'b1;
        #1;
        check("t6_a_valid", 16'(a_valid), 16'h0);
        check("t6_busy", 16'(busy), 16'h0);
        check("t6_sum_ready", 16'(sum_ready), 16'h0);
        check("t6_err_cnt", 16'(err_cnt), 16'h0);
        check("t6_first_err", first_err, 16'hFFFF);
        drop = 1'b0;
        tick();
        rst = 1'b0;
        tick();

        // Rerun repeats the seed sequence; stall a_ready for 20 cycles after 3 transfers
        load_a5();
        chk_ops = 1'b1;
        x0 = op_xfers;
        pulse_start(16'd10);
        for (k = 0; k < 50; k++) begin
            if (op_xfers - x0 >= 3) break;
            tick();
        end
        if (k == 50) fail_now("t3_xfer_timeout");
        stall = 1'b1;
        repeat (20) tick();
        check("t3_a_valid_held", 16'(a_valid), 16'h1);
        check("t3_a_held", 16'(a), 16'hA);
        check("t3_b_held", 16'(b), 16'h2);
        check("t3_no_xfer", 16'(op_xfers - x0), 16'd3);
        stall = 1'b0;
        wait_done(1'b0, 200);
        check("t6_xfers", 16'(op_xfers - x0), 16'd10);
        check("t6_err_cnt_end", 16'(err_cnt), 16'h0);
        check("t6_first_err_end", first_err, 16'hFFFF);
        check("t6_queue_left", 16'(exp_q.size()), 16'h0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
